// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode
// classes, raw opcode values and the datapath field settings per class.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_GRT, C_SUB, C_EQ, C_JALR, C_LUI,
    C_JAL, C_ADDI, C_LW, C_SW, C_LLI, C_BNE
  } cls_t;

  // Raw opcode values; anything not listed decodes as bne.
  localparam logic [3:0] OPC_ADD  = 4'b0000;
  localparam logic [3:0] OPC_GRT  = 4'b0001;
  localparam logic [3:0] OPC_SUB  = 4'b0010;
  localparam logic [3:0] OPC_EQ   = 4'b0011;
  localparam logic [3:0] OPC_JALR = 4'b0100;
  localparam logic [3:0] OPC_LUI  = 4'b0101;
  localparam logic [3:0] OPC_JAL  = 4'b0110;
  localparam logic [3:0] OPC_ADDI = 4'b1000;
  localparam logic [3:0] OPC_LW   = 4'b1001;
  localparam logic [3:0] OPC_SW   = 4'b1010;
  localparam logic [3:0] OPC_LLI  = 4'b1111;

  // Immediate generator formats.
  localparam logic [1:0] IMM_I  = 2'd0;
  localparam logic [1:0] IMM_U  = 2'd1;
  localparam logic [1:0] IMM_J  = 2'd2;
  localparam logic [1:0] IMM_SB = 2'd3;

  // ALU operation: adder or subtractor (compares reuse the subtractor).
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Operand muxes.
  localparam logic       IN1_RS1 = 1'b0;
  localparam logic       IN1_PC  = 1'b1;
  localparam logic [1:0] IN2_RS2 = 2'd0;
  localparam logic [1:0] IN2_IMM = 2'd1;

  // Result select: sum, greater-than flag, equal flag, raw immediate.
  localparam logic [1:0] SRC_SUM = 2'd0;
  localparam logic [1:0] SRC_GT  = 2'd1;
  localparam logic [1:0] SRC_EQ  = 2'd2;
  localparam logic [1:0] SRC_IMM = 2'd3;

  typedef struct packed {
    logic [1:0] immgen;
    logic       alu_op;
    logic       alu_in1;
    logic [1:0] alu_in2;
    logic [1:0] alu_src;
  } fields_t;

  localparam fields_t F_ADD  = '{IMM_I,  ALU_ADD, IN1_RS1, IN2_RS2, SRC_SUM};
  localparam fields_t F_GRT  = '{IMM_I,  ALU_SUB, IN1_RS1, IN2_RS2, SRC_GT};
  localparam fields_t F_SUB  = '{IMM_I,  ALU_SUB, IN1_RS1, IN2_RS2, SRC_SUM};
  localparam fields_t F_EQ   = '{IMM_I,  ALU_SUB, IN1_RS1, IN2_RS2, SRC_EQ};
  localparam fields_t F_JALR = '{IMM_I,  ALU_ADD, IN1_RS1, IN2_IMM, SRC_SUM};
  localparam fields_t F_LUI  = '{IMM_U,  ALU_ADD, IN1_RS1, IN2_IMM, SRC_IMM};
  localparam fields_t F_JAL  = '{IMM_J,  ALU_ADD, IN1_PC,  IN2_IMM, SRC_SUM};
  localparam fields_t F_ADDI = '{IMM_I,  ALU_ADD, IN1_RS1, IN2_IMM, SRC_SUM};
  localparam fields_t F_LW   = '{IMM_I,  ALU_ADD, IN1_RS1, IN2_IMM, SRC_SUM};
  localparam fields_t F_SW   = '{IMM_SB, ALU_ADD, IN1_RS1, IN2_IMM, SRC_SUM};
  localparam fields_t F_LLI  = '{IMM_I,  ALU_ADD, IN1_RS1, IN2_IMM, SRC_IMM};
  localparam fields_t F_BNE  = '{IMM_SB, ALU_SUB, IN1_RS1, IN2_RS2, SRC_SUM};

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface multicycle_control_if #(
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 1
);
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic [1:0]         immgen_op;
  logic [ALUOP_W-1:0] alu_op;
  logic               alu_in1;
  logic [1:0]         alu_in2;
  logic [1:0]         alu_src;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               pc_write;
  logic               pc_cond;
  logic               reg_write;
  logic               mem2reg;
  logic               fault;

  modport master (
    input  op, mem_ready,
    output immgen_op, alu_op, alu_in1, alu_in2, alu_src,
           mem_read, mem_write, ir_write, pc_write, pc_cond,
           reg_write, mem2reg, fault
  );

  modport slave (
    output op, mem_ready,
    input  immgen_op, alu_op, alu_in1, alu_in2, alu_src,
           mem_read, mem_write, ir_write, pc_write, pc_cond,
           reg_write, mem2reg, fault
  );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decode: opcode -> class and datapath fields.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  output cls_t            cls,
  output fields_t         fld
);

  // Opcode to class; unknown opcodes fall through to bne.
  always_comb begin
    cls = C_BNE;
    case (op)
      OP_W'(OPC_ADD):  cls = C_ADD;
      OP_W'(OPC_GRT):  cls = C_GRT;
      OP_W'(OPC_SUB):  cls = C_SUB;
      OP_W'(OPC_EQ):   cls = C_EQ;
      OP_W'(OPC_JALR): cls = C_JALR;
      OP_W'(OPC_LUI):  cls = C_LUI;
      OP_W'(OPC_JAL):  cls = C_JAL;
      OP_W'(OPC_ADDI): cls = C_ADDI;
      OP_W'(OPC_LW):   cls = C_LW;
      OP_W'(OPC_SW):   cls = C_SW;
      OP_W'(OPC_LLI):  cls = C_LLI;
      default:         cls = C_BNE;
    endcase
  end

  // Class to datapath field settings.
  always_comb begin
    fld = F_BNE;
    case (cls)
      C_ADD:   fld = F_ADD;
      C_GRT:   fld = F_GRT;
      C_SUB:   fld = F_SUB;
      C_EQ:    fld = F_EQ;
      C_JALR:  fld = F_JALR;
      C_LUI:   fld = F_LUI;
      C_JAL:   fld = F_JAL;
      C_ADDI:  fld = F_ADDI;
      C_LW:    fld = F_LW;
      C_SW:    fld = F_SW;
      C_LLI:   fld = F_LLI;
      default: fld = F_BNE;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB FSM with a memory
// wait watchdog that parks the machine in FAULT until reset.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int ALUOP_W  = 1,
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  multicycle_control_if.master bus
);

  state_t  st, st_nxt;
  cls_t    cls_q, cls_dec, cls_cur;
  fields_t fld_dec, fld_cur, fld_q;
  logic [7:0] cnt;
  logic       timeout;
  logic       fetch_hs;
  logic       mem_read_q, mem_write_q, pc_write_q, pc_cond_q;
  logic       reg_write_q, mem2reg_q, fault_q;

  ctrl_decode #(.OP_W(OP_W)) u_dec (
    .op  (bus.op),
    .cls (cls_dec),
    .fld (fld_dec)
  );

  assign timeout = (cnt == 8'(WAIT_MAX));

  // In DECODE the class register is being loaded, so look through to the
  // decoder; afterwards the registered class / output fields are current.
  assign cls_cur = (st == ST_DECODE) ? cls_dec : cls_q;
  assign fld_cur = (st == ST_DECODE) ? fld_dec : fld_q;

  // Next-state selection; a handshake in the timeout cycle still completes.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_FETCH: begin
        if (bus.mem_ready)  st_nxt = ST_DECODE;
        else if (timeout)   st_nxt = ST_FAULT;
      end
      ST_DECODE: st_nxt = ST_EXEC;
      ST_EXEC: begin
        case (cls_q)
          C_LW, C_SW:     st_nxt = ST_MEM;
          C_JALR, C_BNE:  st_nxt = ST_FETCH;
          default:        st_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready)  st_nxt = (cls_q == C_LW) ? ST_WB : ST_FETCH;
        else if (timeout)   st_nxt = ST_FAULT;
      end
      ST_WB:    st_nxt = ST_FETCH;
      ST_FAULT: st_nxt = ST_FAULT;
      default:  st_nxt = ST_FETCH;
    endcase
  end

  // FSM state, class register, wait counter and registered outputs for the
  // state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= ST_FETCH;
      cls_q       <= C_ADD;
      cnt         <= '0;
      fld_q       <= '0;
      mem_read_q  <= 1'b1;
      mem_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      pc_cond_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st == ST_DECODE) cls_q <= cls_dec;

      if (st_nxt != st)
        cnt <= '0;
      else if (!bus.mem_ready && (st == ST_FETCH || st == ST_MEM))
        cnt <= cnt + 8'd1;

      fld_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      pc_cond_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      fault_q     <= 1'b0;
      case (st_nxt)
        ST_FETCH: mem_read_q <= 1'b1;
        ST_EXEC: begin
          fld_q      <= fld_cur;
          pc_write_q <= (cls_cur == C_JAL) || (cls_cur == C_JALR);
          pc_cond_q  <= (cls_cur == C_BNE);
        end
        ST_MEM: begin
          fld_q       <= fld_cur;
          mem_read_q  <= (cls_cur == C_LW);
          mem_write_q <= (cls_cur == C_SW);
        end
        ST_WB: begin
          fld_q       <= fld_cur;
          reg_write_q <= 1'b1;
          mem2reg_q   <= (cls_cur == C_LW);
        end
        ST_FAULT: fault_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // The fetch strobes must fire in the very cycle memory answers, so they
  // are qualified combinationally; reset masks them so the reset image holds.
  assign fetch_hs = reset && (st == ST_FETCH) && bus.mem_ready;

  assign bus.immgen_op = fld_q.immgen;
  assign bus.alu_op    = ALUOP_W'(fld_q.alu_op);
  assign bus.alu_in1   = fld_q.alu_in1;
  assign bus.alu_in2   = fld_q.alu_in2;
  assign bus.alu_src   = fld_q.alu_src;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.ir_write  = fetch_hs;
  assign bus.pc_write  = pc_write_q | fetch_hs;
  assign bus.pc_cond   = pc_cond_q;
  assign bus.reg_write = reg_write_q;
  assign bus.mem2reg   = mem2reg_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle strobe and field checks
// against hand-computed vectors.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_control_if #(.OP_W(4), .ALUOP_W(1)) bus ();

  multicycle_control #(.OP_W(4), .ALUOP_W(1), .WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {mem_read, mem_write, ir_write, pc_write, pc_cond, reg_write, mem2reg, fault}
  logic [7:0] strb;
  // {immgen_op[1:0], alu_op, alu_in1, alu_in2[1:0], alu_src[1:0]}
  logic [7:0] fld;
  assign strb = {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                 bus.pc_cond, bus.reg_write, bus.mem2reg, bus.fault};
  assign fld  = {bus.immgen_op, bus.alu_op, bus.alu_in1, bus.alu_in2, bus.alu_src};

  localparam logic [7:0] S_FI  = 8'h80; // fetch waiting / lw MEM
  localparam logic [7:0] S_FH  = 8'hB0; // fetch handshake
  localparam logic [7:0] S_NO  = 8'h00;
  localparam logic [7:0] S_JP  = 8'h10; // pc_write
  localparam logic [7:0] S_BR  = 8'h08; // pc_cond
  localparam logic [7:0] S_WB  = 8'h04;
  localparam logic [7:0] S_WBM = 8'h06;
  localparam logic [7:0] S_WR  = 8'h40;
  localparam logic [7:0] S_FLT = 8'h01;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, check outputs, advance past the edge.
  task automatic step(input string tag, input logic mr,
                      input logic [7:0] es, input logic [7:0] ef);
    bus.mem_ready = mr;
    #1;
    chk({tag, ".strb"}, strb, es);
    chk({tag, ".fld"}, fld, ef);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.op = 4'b0000;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.strb", strb, S_FI);
    chk("rst.fld", fld, S_NO);
    reset = 1'b1;

    // add: 4 cycles, reg_write only in WB
    step("add.F", 1'b1, S_FH, 8'h00);
    step("add.D", 1'b1, S_NO, 8'h00);
    step("add.E", 1'b1, S_NO, 8'h00);
    step("add.W", 1'b1, S_WB, 8'h00);

    // lw with three waiting MEM cycles
    bus.op = 4'b1001;
    step("lw.F", 1'b1, S_FH, 8'h00);
    step("lw.D", 1'b1, S_NO, 8'h00);
    step("lw.E", 1'b1, S_NO, 8'h04);
    for (int i = 0; i < 3; i++) step("lw.Mw", 1'b0, S_FI, 8'h04);
    step("lw.M", 1'b1, S_FI, 8'h04);
    step("lw.W", 1'b1, S_WBM, 8'h04);

    // sw: mem_write only in MEM, back to fetch
    bus.op = 4'b1010;
    step("sw.F", 1'b1, S_FH, 8'h00);
    step("sw.D", 1'b1, S_NO, 8'h00);
    step("sw.E", 1'b1, S_NO, 8'hC4);
    step("sw.M", 1'b1, S_WR, 8'hC4);

    // undefined opcode 1100 behaves as bne
    bus.op = 4'b1100;
    step("bne.F", 1'b1, S_FH, 8'h00);
    step("bne.D", 1'b1, S_NO, 8'h00);
    step("bne.E", 1'b1, S_BR, 8'hE0);

    // jal: pc_write in EXEC, reg_write in WB
    bus.op = 4'b0110;
    step("jal.F", 1'b1, S_FH, 8'h00);
    step("jal.D", 1'b1, S_NO, 8'h00);
    step("jal.E", 1'b1, S_JP, 8'h94);
    step("jal.W", 1'b1, S_WB, 8'h94);

    // jalr: 3-cycle
    bus.op = 4'b0100;
    step("jalr.F", 1'b1, S_FH, 8'h00);
    step("jalr.D", 1'b1, S_NO, 8'h00);
    step("jalr.E", 1'b1, S_JP, 8'h04);

    // lui / grt / eq / lli field patterns
    bus.op = 4'b0101;
    step("lui.F", 1'b1, S_FH, 8'h00);
    step("lui.D", 1'b1, S_NO, 8'h00);
    step("lui.E", 1'b1, S_NO, 8'h47);
    step("lui.W", 1'b1, S_WB, 8'h47);
    bus.op = 4'b0001;
    step("grt.F", 1'b1, S_FH, 8'h00);
    step("grt.D", 1'b1, S_NO, 8'h00);
    step("grt.E", 1'b1, S_NO, 8'h21);
    step("grt.W", 1'b1, S_WB, 8'h21);
    bus.op = 4'b0011;
    step("eq.F", 1'b1, S_FH, 8'h00);
    step("eq.D", 1'b1, S_NO, 8'h00);
    step("eq.E", 1'b1, S_NO, 8'h22);
    step("eq.W", 1'b1, S_WB, 8'h22);
    bus.op = 4'b1111;
    step("lli.F", 1'b1, S_FH, 8'h00);
    step("lli.D", 1'b1, S_NO, 8'h00);
    step("lli.E", 1'b1, S_NO, 8'h07);
    step("lli.W", 1'b1, S_WB, 8'h07);

    // fetch stalls 15 cycles, answers in the cycle the counter hits WAIT_MAX
    bus.op = 4'b1100;
    for (int i = 0; i < 15; i++) step("stall.Fw", 1'b0, S_FI, 8'h00);
    step("stall.F16", 1'b1, S_FH, 8'h00);
    step("stall.D", 1'b1, S_NO, 8'h00);
    step("stall.E", 1'b1, S_BR, 8'hE0);

    // no answer for 16 cycles: FAULT, sticky
    for (int i = 0; i < 16; i++) step("to.Fw", 1'b0, S_FI, 8'h00);
    step("to.flt", 1'b1, S_FLT, 8'h00);
    step("to.stk", 1'b0, S_FLT, 8'h00);
    step("to.stk2", 1'b1, S_FLT, 8'h00);

    // reset clears the fault asynchronously
    reset = 1'b0;
    #1;
    chk("to.rst.strb", strb, S_FI);
    chk("to.rst.fld", fld, S_NO);
    #1;
    reset = 1'b1;

    // reset in the middle of an lw MEM wait
    bus.op = 4'b1001;
    step("lwr.F", 1'b1, S_FH, 8'h00);
    step("lwr.D", 1'b1, S_NO, 8'h00);
    step("lwr.E", 1'b1, S_NO, 8'h04);
    bus.mem_ready = 1'b0;
    #1;
    chk("lwr.M.fld", fld, 8'h04);
    reset = 1'b0;
    #1;
    chk("lwr.rst.strb", strb, S_FI);
    chk("lwr.rst.fld", fld, S_NO);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("lwr.hold.strb", strb, S_FI);
    reset = 1'b1;
    bus.op = 4'b0000;
    step("lwr.F1", 1'b1, S_FH, 8'h00);
    step("lwr.D1", 1'b1, S_NO, 8'h00);
    step("lwr.E1", 1'b1, S_NO, 8'h00);
    step("lwr.W1", 1'b1, S_WB, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
